// File: rtl/control_fsm.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | control_fsm: multi-cycle RV32I control sequencer (boot/fetch/decode/   |
// | exec/mem/wb) with halt, trap and retired-instruction counter.          |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module control_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  lorbtype,
    input  logic [3:0]  alu_action,
    input  logic        zero,
    input  logic        halt_req,
    output logic        PCsel1,
    output logic        PCsel0,
    output logic        enPC,
    output logic        ALUsrc,
    output logic [2:0]  immsrc,
    output logic        memtoreg1,
    output logic        memtoreg0,
    output logic        read_mem,
    output logic        write_mem,
    output logic        enW,
    output logic [4:0]  opr,
    output logic        halted,
    output logic        trap,
    output logic [31:0] instret
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [4:0] OPR_ADD   = 5'b00000;
    localparam logic [4:0] OPR_SUB   = 5'b01000;
    localparam logic [4:0] OPR_SLT   = 5'b00010;
    localparam logic [4:0] OPR_SLTU  = 5'b00011;
    localparam logic [4:0] OPR_PASSB = 5'b01111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    typedef enum logic [2:0] {
        BOOT   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6,
        TRAP   = 3'd7
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [1:0] pc_sel;
    logic [1:0] mem_to_reg;
    logic       final_cycle;
    logic       branch_taken;
    logic [4:0] branch_opr;

    logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc, legal;

    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_lui    = (opcode == OP_LUI);
    assign is_auipc  = (opcode == OP_AUIPC);
    assign legal     = is_r | is_i | is_load | is_store | is_branch |
                       is_jal | is_jalr | is_lui | is_auipc;

    // zero reflects SUB for eq/ne and SLT/SLTU result for the ordered compares
    always_comb begin
        branch_opr   = OPR_ADD;
        branch_taken = 1'b0;
        case (lorbtype)
            3'b000: begin branch_opr = OPR_SUB;  branch_taken = zero;  end
            3'b001: begin branch_opr = OPR_SUB;  branch_taken = !zero; end
            3'b100: begin branch_opr = OPR_SLT;  branch_taken = !zero; end
            3'b101: begin branch_opr = OPR_SLT;  branch_taken = zero;  end
            3'b110: begin branch_opr = OPR_SLTU; branch_taken = !zero; end
            3'b111: begin branch_opr = OPR_SLTU; branch_taken = zero;  end
            default: begin branch_opr = OPR_ADD; branch_taken = 1'b0;  end
        endcase
    end

    always_comb begin
        pc_sel      = 2'b00;
        enPC        = 1'b0;
        ALUsrc      = 1'b0;
        immsrc      = IMM_I;
        mem_to_reg  = 2'b00;
        read_mem    = 1'b0;
        write_mem   = 1'b0;
        enW         = 1'b0;
        opr         = OPR_ADD;
        next_state  = state;
        final_cycle = 1'b0;

        // per-class datapath controls stay put across EXEC/MEM/WB
        if (state == EXEC || state == MEM || state == WB) begin
            if (is_r) begin
                opr = {1'b0, alu_action};
            end else if (is_i) begin
                ALUsrc = 1'b1;
                opr    = {1'b0, alu_action};
            end else if (is_load) begin
                ALUsrc = 1'b1;
            end else if (is_store) begin
                ALUsrc = 1'b1;
                immsrc = IMM_S;
            end else if (is_lui) begin
                ALUsrc = 1'b1;
                immsrc = IMM_U;
                opr    = OPR_PASSB;
            end else if (is_auipc) begin
                immsrc     = IMM_U;
                mem_to_reg = 2'b10;
            end else if (is_jal) begin
                immsrc     = IMM_J;
                mem_to_reg = 2'b11;
            end else if (is_jalr) begin
                ALUsrc     = 1'b1;
                mem_to_reg = 2'b11;
            end else if (is_branch) begin
                immsrc = IMM_B;
                opr    = branch_opr;
            end
        end

        case (state)
            BOOT: begin
                pc_sel     = 2'b11;
                enPC       = 1'b1;
                next_state = FETCH;
            end
            FETCH:  next_state = DECODE;
            DECODE: next_state = legal ? EXEC : TRAP;
            EXEC: begin
                if (is_branch) begin
                    enPC        = 1'b1;
                    pc_sel      = branch_taken ? 2'b01 : 2'b00;
                    final_cycle = 1'b1;
                end else if (is_load || is_store) begin
                    next_state = MEM;
                end else begin
                    next_state = WB;
                end
            end
            MEM: begin
                if (is_store) begin
                    write_mem   = 1'b1;
                    enPC        = 1'b1;
                    final_cycle = 1'b1;
                end else begin
                    read_mem   = 1'b1;
                    next_state = WB;
                end
            end
            WB: begin
                enW         = 1'b1;
                enPC        = 1'b1;
                final_cycle = 1'b1;
                if (is_load) begin
                    read_mem   = 1'b1;
                    mem_to_reg = 2'b01;
                end
                if (is_jal)  pc_sel = 2'b01;
                if (is_jalr) pc_sel = 2'b10;
            end
            HALT: begin
                if (!halt_req) next_state = FETCH;
            end
            TRAP:    next_state = TRAP;
            default: next_state = BOOT;
        endcase

        if (final_cycle) next_state = halt_req ? HALT : FETCH;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= BOOT;
            instret <= 32'd0;
        end else begin
            state <= next_state;
            if (final_cycle) instret <= instret + 32'd1;
        end
    end

    assign PCsel1    = pc_sel[1];
    assign PCsel0    = pc_sel[0];
    assign memtoreg1 = mem_to_reg[1];
    assign memtoreg0 = mem_to_reg[0];
    assign halted    = (state == HALT);
    assign trap      = (state == TRAP);

endmodule
`default_nettype wire

// File: tb/tb_control_fsm.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_control_fsm: table vectors, random instruction stream against a     |
// | phase-based reference model, and reset/halt/trap corner sequences.    |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_control_fsm;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [1:0] pcsel;
        logic       enpc;
        logic       alusrc;
        logic [2:0] imm;
        logic [1:0] m2r;
        logic       rd;
        logic       wr;
        logic       enw;
        logic [4:0] opr;
        logic       halted;
        logic       trap;
    } outs_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] lt;
        logic [3:0] aa;
        logic       z;
        int         lat;
        outs_t      exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  lorbtype;
    logic [3:0]  alu_action;
    logic        zero;
    logic        halt_req;
    logic        PCsel1, PCsel0, enPC, ALUsrc, memtoreg1, memtoreg0;
    logic        read_mem, write_mem, enW, halted, trap;
    logic [2:0]  immsrc;
    logic [4:0]  opr;
    logic [31:0] instret;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_instret = 0;
    vec_t        vecs[$];
    outs_t       boot_o, halt_o, trap_o;

    control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .lorbtype(lorbtype),
        .alu_action(alu_action), .zero(zero), .halt_req(halt_req),
        .PCsel1(PCsel1), .PCsel0(PCsel0), .enPC(enPC), .ALUsrc(ALUsrc),
        .immsrc(immsrc), .memtoreg1(memtoreg1), .memtoreg0(memtoreg0),
        .read_mem(read_mem), .write_mem(write_mem), .enW(enW), .opr(opr),
        .halted(halted), .trap(trap), .instret(instret)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic outs_t capture();
        outs_t o;
        o.pcsel = {PCsel1, PCsel0}; o.enpc = enPC; o.alusrc = ALUsrc;
        o.imm = immsrc; o.m2r = {memtoreg1, memtoreg0}; o.rd = read_mem;
        o.wr = write_mem; o.enw = enW; o.opr = opr; o.halted = halted;
        o.trap = trap;
        return o;
    endfunction

    task automatic check_outs(input string name, input outs_t act, input outs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: outputs got %05h expected %05h (pcsel,enpc,alusrc,imm,m2r,rd,wr,enw,opr,halted,trap)",
                     name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic outs_t mk(input logic [1:0] pcsel, input logic alusrc, input logic [2:0] imm,
                                 input logic [1:0] m2r, input logic rd, input logic wr,
                                 input logic enw, input logic [4:0] opr);
        outs_t o = '0;
        o.pcsel = pcsel; o.enpc = 1'b1; o.alusrc = alusrc; o.imm = imm; o.m2r = m2r;
        o.rd = rd; o.wr = wr; o.enw = enw; o.opr = opr;
        return o;
    endfunction

    function automatic void add(input logic [6:0] op, input logic [2:0] lt, input logic [3:0] aa,
                                input logic z, input int lat, input outs_t exp);
        vec_t v;
        v.op = op; v.lt = lt; v.aa = aa; v.z = z; v.lat = lat; v.exp = exp;
        vecs.push_back(v);
    endfunction

    // Reference model: instruction cycles numbered from FETCH = 0.
    function automatic int latency(input logic [6:0] op);
        if (op == OP_BRANCH) return 3;
        if (op == OP_LOAD)   return 5;
        return 4;
    endfunction

    function automatic outs_t model_out(input int p, input logic [6:0] op, input logic [2:0] lt,
                                        input logic [3:0] aa, input logic z);
        outs_t o = '0;
        bit taken = 0;
        int n = latency(op);
        if (p < 2) return o;
        case (op)
            OP_R:      o.opr = {1'b0, aa};
            OP_I:      begin o.alusrc = 1; o.opr = {1'b0, aa}; end
            OP_LOAD:   o.alusrc = 1;
            OP_STORE:  begin o.alusrc = 1; o.imm = 3'd1; end
            OP_LUI:    begin o.alusrc = 1; o.imm = 3'd3; o.opr = 5'b01111; end
            OP_AUIPC:  begin o.imm = 3'd3; o.m2r = 2'd2; end
            OP_JAL:    begin o.imm = 3'd4; o.m2r = 2'd3; end
            OP_JALR:   begin o.alusrc = 1; o.m2r = 2'd3; end
            OP_BRANCH: begin
                o.imm = 3'd2;
                if (lt == 0 || lt == 1)      o.opr = 5'b01000;
                else if (lt == 4 || lt == 5) o.opr = 5'b00010;
                else if (lt == 6 || lt == 7) o.opr = 5'b00011;
                // eq/ge take on zero; ne/lt/ltu take on nonzero; 010/011 never
                if (lt == 0 || lt == 5 || lt == 7) taken = z;
                if (lt == 1 || lt == 4 || lt == 6) taken = !z;
            end
            default: ;
        endcase
        if (op == OP_LOAD && p >= 3) o.rd = 1;
        if (p == n - 1) begin
            o.enpc = 1;
            if (op == OP_BRANCH) o.pcsel = taken ? 2'd1 : 2'd0;
            else if (op == OP_STORE) o.wr = 1;
            else begin
                o.enw = 1;
                if (op == OP_LOAD) o.m2r = 2'd1;
                if (op == OP_JAL)  o.pcsel = 2'd1;
                if (op == OP_JALR) o.pcsel = 2'd2;
            end
        end
        return o;
    endfunction

    // Entry/exit: just after a rising edge with the DUT in FETCH.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] lt, input logic [3:0] aa,
                             input logic z, input bit hr_final, input int hold);
        int n = latency(op);
        opcode = op; lorbtype = lt; alu_action = aa; zero = z;
        for (int p = 0; p < n; p++) begin
            halt_req = (p == n - 1) ? hr_final : 1'($urandom_range(0, 1));
            @(negedge clk);
            check_outs($sformatf("model op=%b phase=%0d", op, p), capture(), model_out(p, op, lt, aa, z));
            check_val("instret", instret, exp_instret);
            @(posedge clk); #1;
        end
        exp_instret++;
        if (hr_final) begin
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                check_outs("halt hold", capture(), halt_o);
                check_val("instret in halt", instret, exp_instret);
                @(posedge clk); #1;
            end
            halt_req = 0;
            @(negedge clk);
            check_outs("halt release", capture(), halt_o);
            @(posedge clk); #1;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc = 0;
        bit done = 0;
        outs_t o;
        opcode = v.op; lorbtype = v.lt; alu_action = v.aa; zero = v.z; halt_req = 0;
        while (!done && cyc < 8) begin
            cyc++;
            @(negedge clk);
            o = capture();
            if (o.enpc) begin
                done = 1;
                check_val($sformatf("vec%0d latency", idx), cyc, v.lat);
                check_outs($sformatf("vec%0d final", idx), o, v.exp);
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL vec%0d: no final cycle within 8 cycles", idx);
        end
        exp_instret++;
        check_val($sformatf("vec%0d instret", idx), instret, exp_instret);
    endtask

    task automatic boot_release();
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        check_outs("boot cycle", capture(), boot_o);
        @(posedge clk); #1;
    endtask

    logic [6:0] ops [9];

    initial begin
        boot_o = '0; boot_o.pcsel = 2'b11; boot_o.enpc = 1;
        halt_o = '0; halt_o.halted = 1;
        trap_o = '0; trap_o.trap = 1;
        ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

        add(OP_R,      3'b000, 4'b0000, 0, 4, mk(2'b00, 0, 3'b000, 2'b00, 0, 0, 1, 5'b00000));
        add(OP_R,      3'b000, 4'b1010, 0, 4, mk(2'b00, 0, 3'b000, 2'b00, 0, 0, 1, 5'b01010));
        add(OP_I,      3'b000, 4'b0111, 1, 4, mk(2'b00, 1, 3'b000, 2'b00, 0, 0, 1, 5'b00111));
        add(OP_LOAD,   3'b010, 4'b0000, 0, 5, mk(2'b00, 1, 3'b000, 2'b01, 1, 0, 1, 5'b00000));
        add(OP_STORE,  3'b010, 4'b0000, 0, 4, mk(2'b00, 1, 3'b001, 2'b00, 0, 1, 0, 5'b00000));
        add(OP_LUI,    3'b000, 4'b0000, 0, 4, mk(2'b00, 1, 3'b011, 2'b00, 0, 0, 1, 5'b01111));
        add(OP_AUIPC,  3'b000, 4'b0000, 0, 4, mk(2'b00, 0, 3'b011, 2'b10, 0, 0, 1, 5'b00000));
        add(OP_JAL,    3'b000, 4'b0000, 0, 4, mk(2'b01, 0, 3'b100, 2'b11, 0, 0, 1, 5'b00000));
        add(OP_JALR,   3'b000, 4'b0000, 0, 4, mk(2'b10, 1, 3'b000, 2'b11, 0, 0, 1, 5'b00000));
        add(OP_BRANCH, 3'b001, 4'b0000, 0, 3, mk(2'b01, 0, 3'b010, 2'b00, 0, 0, 0, 5'b01000));
        add(OP_BRANCH, 3'b001, 4'b0000, 1, 3, mk(2'b00, 0, 3'b010, 2'b00, 0, 0, 0, 5'b01000));
        add(OP_BRANCH, 3'b000, 4'b0000, 1, 3, mk(2'b01, 0, 3'b010, 2'b00, 0, 0, 0, 5'b01000));
        add(OP_BRANCH, 3'b100, 4'b0000, 0, 3, mk(2'b01, 0, 3'b010, 2'b00, 0, 0, 0, 5'b00010));
        add(OP_BRANCH, 3'b101, 4'b0000, 0, 3, mk(2'b00, 0, 3'b010, 2'b00, 0, 0, 0, 5'b00010));
        add(OP_BRANCH, 3'b110, 4'b0000, 1, 3, mk(2'b00, 0, 3'b010, 2'b00, 0, 0, 0, 5'b00011));
        add(OP_BRANCH, 3'b111, 4'b0000, 1, 3, mk(2'b01, 0, 3'b010, 2'b00, 0, 0, 0, 5'b00011));
        add(OP_BRANCH, 3'b010, 4'b0000, 1, 3, mk(2'b00, 0, 3'b010, 2'b00, 0, 0, 0, 5'b00000));

        reset = 1; opcode = OP_R; lorbtype = 0; alu_action = 0; zero = 0; halt_req = 0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset outputs", capture(), boot_o);
        check_val("reset instret", instret, 0);
        boot_release();

        foreach (vecs[i]) run_vec(vecs[i], i);

        for (int i = 0; i < 60; i++)
            run_instr(ops[$urandom_range(0, 8)], 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), $urandom_range(1, 3));

        // halt requested in the final cycle of a JALR
        run_instr(OP_JALR, 3'b000, 4'b0000, 0, 1, 2);
        run_instr(OP_R, 3'b000, 4'b0011, 0, 0, 0);

        // reset in the middle of a store's MEM cycle
        opcode = OP_STORE; halt_req = 0;
        repeat (3) @(posedge clk);
        #2;
        check_val("store mem write_mem", write_mem, 1);
        reset = 1;
        #1;
        check_val("reset write_mem", write_mem, 0);
        check_val("reset mid-store instret", instret, 0);
        check_outs("reset mid-store outputs", capture(), boot_o);
        exp_instret = 0;
        boot_release();

        // illegal opcode traps until reset
        opcode = 7'b0000000;
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            check_outs("illegal fetch/decode", capture(), '0);
            @(posedge clk); #1;
        end
        for (int k = 0; k < 10; k++) begin
            halt_req = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_outs($sformatf("trap cycle %0d", k), capture(), trap_o);
            @(posedge clk); #1;
        end
        check_val("trap instret", instret, exp_instret);
        #2;
        reset = 1;
        #1;
        check_outs("reset from trap", capture(), boot_o);
        halt_req = 0;
        boot_release();
        run_instr(OP_LOAD, 3'b010, 4'b0000, 0, 0, 0);
        check_val("instret after trap recovery", instret, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have a single clock and a reset that is asynchronous and active-high; reset port named reset, clock port named clk.
REQ-002 SHALL expose ports (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- reset  in  1  async active-high reset
- opcode  in  7  decoded instruction opcode from datapath
- lorbtype  in  3  funct3 (load/branch/store type)
- alu_action  in  4  decoded ALU operation for R/I-ALU
- zero  in  1  ALU result==0
- halt_req  in  1  request stop after current instruction
- PCsel1, PCsel0  out  1 each  PC mux: 00 PC+4, 01 PC+imm, 10 ALUresult, 11 initialize
- enPC  out  1  PC load enable
- ALUsrc  out  1  0 rs2, 1 immediate
- immsrc  out  3  000 I, 001 S, 010 B, 011 U, 100 J
- memtoreg1, memtoreg0  out  1 each  00 ALU, 01 mem, 10 PC+imm, 11 PC+4
- read_mem, write_mem, enW  out  1 each  memory read, memory write, regfile write
- opr  out  5  ALU op: ADD 00000, SUB 01000, SLT 00010, SLTU 00011, PASSB 01111, else {0,alu_action}
- halted  out  1  FSM in HALT
- trap  out  1  illegal opcode seen
- instret  out  32  retired-instruction count

Function
REQ-003 SHALL implement states BOOT, FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP in a registered state; control outputs are combinational from state, opcode, lorbtype, zero.
REQ-004 Defaults (any output not listed for a state): PCsel=00, enPC=0, ALUsrc=0, immsrc=000, memtoreg=00, read_mem=0, write_mem=0, enW=0, opr=ADD.
REQ-005 BOOT: PCsel=11, enPC=1 for exactly one cycle, then FETCH.
REQ-006 FETCH -> DECODE unconditionally; DECODE -> TRAP if opcode not in {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111}, else EXEC.
REQ-007 In EXEC, MEM and WB, per-class datapath controls SHALL be held stable: R: ALUsrc=0, opr={0,alu_action}; I-ALU: ALUsrc=1, immsrc=I, opr={0,alu_action}; load: ALUsrc=1, immsrc=I, ADD; store: ALUsrc=1, immsrc=S, ADD; LUI: ALUsrc=1, immsrc=U, PASSB; AUIPC: immsrc=U, memtoreg=10; JAL: immsrc=J, memtoreg=11; JALR: ALUsrc=1, immsrc=I, ADD, memtoreg=11; branch: immsrc=B, ALUsrc=0.
REQ-008 Branch opr by lorbtype: 000/001 SUB, 100/101 SLT, 110/111 SLTU; taken = (000 & zero) | (001 & !zero) | (100,110 & !zero) | (101,111 & zero); 010/011 never taken.
REQ-009 Branch: EXEC is final cycle; enPC=1, PCsel=01 if taken else 00.
REQ-010 Store: EXEC -> MEM; MEM final cycle with write_mem=1, enPC=1, PCsel=00.
REQ-011 Load: EXEC -> MEM (read_mem=1) -> WB; WB holds read_mem=1, memtoreg=01, enW=1, enPC=1, PCsel=00.
REQ-012 R, I-ALU, LUI, AUIPC, JAL, JALR: EXEC -> WB; WB final cycle with enW=1, enPC=1; PCsel=01 for JAL, 10 for JALR, else 00.
REQ-013 Latency in cycles FETCH..final: branch 3, store 4, ALU/LUI/AUIPC/JAL/JALR 4, load 5.
REQ-014 enW and write_mem SHALL never assert in the same cycle; each asserts at most one cycle per instruction.
REQ-015 In the final cycle, halt_req=1 -> HALT, else FETCH.
REQ-016 HALT: defaults, halted=1; halt_req=0 -> FETCH next cycle.
REQ-017 TRAP: defaults, trap=1; no exit except reset.
REQ-018 instret SHALL increment by 1 in each instruction's final cycle (not BOOT), wrapping FFFFFFFF -> 00000000.

Reset
REQ-019 Asserting reset SHALL immediately force state=BOOT, instret=0, halted=0, trap=0, mid-instruction included; outputs then take BOOT values (PCsel=11, enPC=1, all write enables 0).
REQ-020 After deassertion, one BOOT cycle precedes the first FETCH.

Verification
REQ-021 Reset, then opcode=0110011, alu_action=0000 -> BOOT, FETCH, DECODE, EXEC, WB; WB: enW=1, enPC=1, PCsel=00, memtoreg=00; instret=1.
REQ-022 opcode=1100011, lorbtype=001, zero=0 -> EXEC: opr=01000, enPC=1, PCsel=01; with zero=1 -> PCsel=00; enW=0 throughout.
REQ-023 opcode=0000011 -> MEM read_mem=1, enW=0; WB read_mem=1, memtoreg=01, enW=1; 5 cycles FETCH..WB.
REQ-024 opcode=0000000 at DECODE -> TRAP, trap=1, all enables 0 for 10 cycles; reset returns to BOOT with trap=0.
REQ-025 halt_req=1 during a JALR WB -> WB PCsel=10, memtoreg=11, then HALT with halted=1; drop halt_req -> FETCH next cycle.
REQ-026 Assert reset during a store MEM cycle -> write_mem drops immediately, instret=0, state BOOT.
